// File: rtl/basilisk_writeback.sv
// basilisk_writeback: round-robin writeback of execution-unit results
// into the vector register file, with per-register part completion.
module basilisk_writeback #(
  parameter int PORTS        = 6,
  parameter int PARTS        = 4,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PORTS-1:0]                      result_valid,
  output logic [PORTS-1:0]                      result_ready,
  input  logic [PORTS*(37+OFFSET_WIDTH)-1:0]    result_data,
  output logic                                  wb_enable,
  output logic [4:0]                            wb_reg_addr,
  output logic [OFFSET_WIDTH-1:0]               wb_offset_addr,
  output logic [31:0]                           wb_data,
  output logic                                  complete_valid,
  output logic [4:0]                            complete_reg_addr,
  output logic                                  overlap_error
);

  localparam int DW = 37 + OFFSET_WIDTH;
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef struct packed {
    logic [4:0]              dest_reg_addr;
    logic [OFFSET_WIDTH-1:0] dest_offset_addr;
    logic [31:0]             value;
  } basilisk_writeback_result_t;

  logic [PW-1:0]              r_ptr;
  logic [PARTS-1:0]           r_mask [32];

  logic                       w_found;
  logic [PW-1:0]              w_grant;
  basilisk_writeback_result_t w_sel;
  logic [PARTS-1:0]           w_cur;
  logic [PARTS-1:0]           w_bit;
  logic [PARTS-1:0]           w_new;
  logic                       w_dup;
  logic                       w_done;

  always_comb begin : arb
    int idx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = 0;
    for (int i = 0; i < PORTS; i++) begin
      idx = (int'(r_ptr) + i) % PORTS;
      if (!w_found && result_valid[idx]) begin
        w_found = 1'b1;
        w_grant = PW'(idx);
      end
    end
  end

  assign result_ready = w_found ? (PORTS'(1) << w_grant) : '0;
  assign w_sel = basilisk_writeback_result_t'(
    result_data[int'(w_grant)*DW +: DW]);

  // Out-of-range offsets yield an empty bit and count as overlap.
  assign w_cur  = r_mask[w_sel.dest_reg_addr];
  assign w_bit  = (int'(w_sel.dest_offset_addr) < PARTS)
                ? (PARTS'(1) << w_sel.dest_offset_addr) : '0;
  assign w_dup  = (w_bit == '0) || ((w_cur & w_bit) != '0);
  assign w_new  = w_cur | w_bit;
  assign w_done = !w_dup && (w_new == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr             <= '0;
      wb_enable         <= 1'b0;
      wb_reg_addr       <= '0;
      wb_offset_addr    <= '0;
      wb_data           <= '0;
      complete_valid    <= 1'b0;
      complete_reg_addr <= '0;
      overlap_error     <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_mask[i] <= '0;
      end
    end else begin
      wb_enable      <= w_found;
      complete_valid <= w_found && w_done;
      if (w_found) begin
        wb_reg_addr    <= w_sel.dest_reg_addr;
        wb_offset_addr <= w_sel.dest_offset_addr;
        wb_data        <= w_sel.value;
        r_ptr <= (w_grant == PW'(PORTS - 1)) ? '0 : w_grant + PW'(1);
        if (w_dup) begin
          overlap_error <= 1'b1;
        end else if (w_done) begin
          r_mask[w_sel.dest_reg_addr] <= '0;
          complete_reg_addr           <= w_sel.dest_reg_addr;
        end else begin
          r_mask[w_sel.dest_reg_addr] <= w_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_basilisk_writeback.sv
// Bench for basilisk_writeback: directed scenarios then random traffic
// checked against a queue-free behavioural model of arbitration and masks.
module tb_basilisk_writeback;

  localparam int P  = 6;
  localparam int DW = 39;

  logic            clk = 1'b0;
  logic            rst;
  logic [P-1:0]    result_valid;
  logic [P-1:0]    result_ready;
  logic [P*DW-1:0] result_data;
  logic            wb_enable;
  logic [4:0]      wb_reg_addr;
  logic [1:0]      wb_offset_addr;
  logic [31:0]     wb_data;
  logic            complete_valid;
  logic [4:0]      complete_reg_addr;
  logic            overlap_error;

  basilisk_writeback #(
    .PORTS(6), .PARTS(4), .OFFSET_WIDTH(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .result_valid      (result_valid),
    .result_ready      (result_ready),
    .result_data       (result_data),
    .wb_enable         (wb_enable),
    .wb_reg_addr       (wb_reg_addr),
    .wb_offset_addr    (wb_offset_addr),
    .wb_data           (wb_data),
    .complete_valid    (complete_valid),
    .complete_reg_addr (complete_reg_addr),
    .overlap_error     (overlap_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit          pend_v [P];
  logic [4:0]  pend_r [P];
  logic [1:0]  pend_o [P];
  logic [31:0] pend_d [P];

  int          m_ptr;
  int          m_mask [32];
  logic        e_en, e_cv, e_err;
  logic [4:0]  e_reg, e_cr;
  logic [1:0]  e_off;
  logic [31:0] e_data;
  logic [P-1:0] last_ready;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 32; i++) m_mask[i] = 0;
    for (int i = 0; i < P; i++) pend_v[i] = 1'b0;
    e_en = 0; e_cv = 0; e_err = 0;
    e_reg = 0; e_cr = 0; e_off = 0; e_data = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    result_valid = '0;
    model_reset();
    #2;
    chk("rst_ready", 64'(result_ready), 64'(0));
    chk("rst_en",    64'(wb_enable), 64'(0));
    chk("rst_reg",   64'(wb_reg_addr), 64'(0));
    chk("rst_off",   64'(wb_offset_addr), 64'(0));
    chk("rst_data",  64'(wb_data), 64'(0));
    chk("rst_cv",    64'(complete_valid), 64'(0));
    chk("rst_cr",    64'(complete_reg_addr), 64'(0));
    chk("rst_err",   64'(overlap_error), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic offer(input int p, input logic [4:0] r,
                       input logic [1:0] o, input logic [31:0] d);
    pend_v[p] = 1'b1;
    pend_r[p] = r;
    pend_o[p] = o;
    pend_d[p] = d;
  endtask

  // One clock: drive pending offers, check grant, then check registered outputs.
  task automatic cycle();
    int w;
    int idx;
    int b;
    logic [P-1:0] er;
    for (int p = 0; p < P; p++) begin
      result_valid[p] = pend_v[p];
      result_data[p*DW +: DW] = {pend_r[p], pend_o[p], pend_d[p]};
    end
    w = -1;
    for (int i = 0; i < P; i++) begin
      idx = (m_ptr + i) % P;
      if (w < 0 && pend_v[idx]) w = idx;
    end
    er = (w >= 0) ? P'(1 << w) : '0;
    @(negedge clk);
    chk("ready", 64'(result_ready), 64'(er));
    last_ready = result_ready;
    e_cv = 1'b0;
    if (w >= 0) begin
      e_en   = 1'b1;
      e_reg  = pend_r[w];
      e_off  = pend_o[w];
      e_data = pend_d[w];
      b = 1 << int'(e_off);
      if ((m_mask[e_reg] & b) != 0) begin
        e_err = 1'b1;
      end else begin
        m_mask[e_reg] = m_mask[e_reg] | b;
        if (m_mask[e_reg] == 15) begin
          e_cv = 1'b1;
          e_cr = e_reg;
          m_mask[e_reg] = 0;
        end
      end
      m_ptr = (w + 1) % P;
      pend_v[w] = 1'b0;
    end else begin
      e_en = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("wb_en",   64'(wb_enable), 64'(e_en));
    chk("wb_reg",  64'(wb_reg_addr), 64'(e_reg));
    chk("wb_off",  64'(wb_offset_addr), 64'(e_off));
    chk("wb_data", 64'(wb_data), 64'(e_data));
    chk("cv",      64'(complete_valid), 64'(e_cv));
    chk("err",     64'(overlap_error), 64'(e_err));
    if (e_cv) chk("cr", 64'(complete_reg_addr), 64'(e_cr));
  endtask

  initial begin
    rst = 1'b0;
    result_valid = '0;
    result_data = '0;
    last_ready = '0;
    model_reset();
    #1;
    do_reset();

    // single result
    offer(0, 5'd3, 2'd1, 32'h3F80_0000);
    cycle();
    chk("t1_en",   64'(wb_enable), 64'(1));
    chk("t1_reg",  64'(wb_reg_addr), 64'(3));
    chk("t1_off",  64'(wb_offset_addr), 64'(1));
    chk("t1_data", 64'(wb_data), 64'(32'h3F80_0000));
    chk("t1_cv",   64'(complete_valid), 64'(0));
    cycle();
    chk("t1_idle", 64'(wb_enable), 64'(0));
    chk("t1_hold", 64'(wb_data), 64'(32'h3F80_0000));

    // completion of reg 7 from port 2
    for (int k = 0; k < 4; k++) begin
      offer(2, 5'd7, 2'(k), 32'h100 + 32'(k));
      cycle();
      chk("t2_en", 64'(wb_enable), 64'(1));
      chk("t2_cv", 64'(complete_valid), 64'(k == 3));
    end
    chk("t2_cr", 64'(complete_reg_addr), 64'(7));
    offer(2, 5'd7, 2'd0, 32'h200);
    cycle();
    chk("t2_cv5",  64'(complete_valid), 64'(0));
    chk("t2_err5", 64'(overlap_error), 64'(0));

    // fairness, all ports continuously valid
    do_reset();
    for (int k = 0; k < 7; k++) begin
      for (int p = 0; p < P; p++) begin
        if (!pend_v[p]) offer(p, 5'(8 + p), 2'(k % 4), $urandom);
      end
      cycle();
      chk("t3_order", 64'(last_ready), 64'(1 << (k % P)));
    end

    // contention with gap, pointer at 2
    do_reset();
    offer(1, 5'd1, 2'd0, 32'hA);
    cycle();
    offer(1, 5'd1, 2'd1, 32'hB);
    offer(4, 5'd4, 2'd0, 32'hC);
    cycle();
    chk("t4_first", 64'(last_ready), 64'(6'b010000));
    cycle();
    chk("t4_second", 64'(last_ready), 64'(6'b000010));
    for (int p = 0; p < P; p++) offer(p, 5'(16 + p), 2'd0, 32'(p));
    cycle();
    chk("t4_ptr", 64'(last_ready), 64'(6'b000100));

    // overlap on reg 5 offset 2
    do_reset();
    offer(3, 5'd5, 2'd2, 32'h11);
    cycle();
    chk("t5_err1", 64'(overlap_error), 64'(0));
    offer(3, 5'd5, 2'd2, 32'h22);
    cycle();
    chk("t5_en2",  64'(wb_enable), 64'(1));
    chk("t5_dat2", 64'(wb_data), 64'(32'h22));
    chk("t5_err2", 64'(overlap_error), 64'(1));
    cycle();
    chk("t5_stick", 64'(overlap_error), 64'(1));

    // reset mid-stream on reg 9
    do_reset();
    offer(0, 5'd9, 2'd0, 32'h90);
    cycle();
    offer(0, 5'd9, 2'd1, 32'h91);
    cycle();
    offer(5, 5'd9, 2'd2, 32'h92);
    do_reset();
    for (int k = 2; k < 4; k++) begin
      offer(0, 5'd9, 2'(k), 32'h90 + 32'(k));
      cycle();
      chk("t6_cv", 64'(complete_valid), 64'(0));
    end

    // random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < P; p++) begin
        if (!pend_v[p] && $urandom_range(0, 1) == 1) begin
          offer(p, 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom);
        end
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
